// File: rtl/pc_register.sv
// Fetch-stage program-counter register: clear-to-vector, load with optional LSB alignment, hold on stall.
// Optional macro PC_REGISTER_MISALIGN_EN adds a registered 'misaligned' flag for the last loaded address.
module pc_register #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int unsigned          ALIGN_BITS  = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out
`ifdef PC_REGISTER_MISALIGN_EN
    ,
    output logic             misaligned
`endif
);

    // Ones in the kept positions, zeros in the ALIGN_BITS low positions.
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    // Parameter legality is enforced at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "pc_register: WIDTH must be at least 1");
    end
    if (ALIGN_BITS >= WIDTH) begin : g_bad_align
        $fatal(1, "pc_register: ALIGN_BITS must be in 0..WIDTH-1");
    end
    if ((RESET_VALUE & ~ALIGN_MASK) != '0) begin : g_bad_reset
        $fatal(1, "pc_register: RESET_VALUE low ALIGN_BITS bits must be zero");
    end

    logic [WIDTH-1:0] r_pc = RESET_VALUE;
    logic [WIDTH-1:0] w_pc_aligned;

    assign w_pc_aligned = pc_in & ALIGN_MASK;

    // Clear has priority over load; no load means stall.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc <= RESET_VALUE;
        end else if (load) begin
            r_pc <= w_pc_aligned;
        end
    end

    assign pc_out = r_pc;

`ifdef PC_REGISTER_MISALIGN_EN
    logic r_misaligned = 1'b0;
    logic w_low_nonzero;

    // Masked-off bits are identically zero when ALIGN_BITS is 0, so the flag stays low.
    assign w_low_nonzero = |(pc_in & ~ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_misaligned <= 1'b0;
        end else if (load) begin
            r_misaligned <= w_low_nonzero;
        end
    end

    assign misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: default instance plus an aligned instance with a non-zero reset vector.
module tb_pc_register;

    localparam int unsigned W   = 32;
    localparam logic [W-1:0] RV1 = 32'h0040_0000;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         clr0 = 1'b0, load0 = 1'b0;
    logic [W-1:0] pc_in0 = '0;
    logic [W-1:0] pc_out0;
    logic         clr1 = 1'b0, load1 = 1'b0;
    logic [W-1:0] pc_in1 = '0;
    logic [W-1:0] pc_out1;
`ifdef PC_REGISTER_MISALIGN_EN
    logic         mis0, mis1;
`endif

    pc_register #(.WIDTH(W)) dut0 (
        .clk(clk), .clr(clr0), .load(load0), .pc_in(pc_in0), .pc_out(pc_out0)
`ifdef PC_REGISTER_MISALIGN_EN
        , .misaligned(mis0)
`endif
    );

    pc_register #(.WIDTH(W), .RESET_VALUE(RV1), .ALIGN_BITS(2)) dut1 (
        .clk(clk), .clr(clr1), .load(load1), .pc_in(pc_in1), .pc_out(pc_out1)
`ifdef PC_REGISTER_MISALIGN_EN
        , .misaligned(mis1)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         qm0[$];
    logic         qm1[$];
    logic [W-1:0] m0  = '0;
    logic [W-1:0] m1  = RV1;
    logic         mm0 = 1'b0;
    logic         mm1 = 1'b0;

    // One clock of stimulus on dut0: mid-cycle no-glitch check, then post-edge scoreboard check.
    task automatic step0(input logic c, input logic l, input logic [W-1:0] d, input string name);
        logic [W-1:0] exp_pc;
        logic         exp_m;
        @(negedge clk);
        clr0 = c; load0 = l; pc_in0 = d;
        #1;
        checks++;
        if (pc_out0 !== m0) begin
            errors++;
            $display("FAIL %s_comb: pc_out=%h expected %h", name, pc_out0, m0);
        end
        if (c) begin
            m0 = '0; mm0 = 1'b0;
        end else if (l) begin
            m0 = d; mm0 = 1'b0;
        end
        q0.push_back(m0);
        qm0.push_back(mm0);
        @(posedge clk);
        #1;
        exp_pc = q0.pop_front();
        exp_m  = qm0.pop_front();
        checks++;
        if (pc_out0 !== exp_pc) begin
            errors++;
            $display("FAIL %s: pc_out=%h expected %h", name, pc_out0, exp_pc);
        end
`ifdef PC_REGISTER_MISALIGN_EN
        checks++;
        if (mis0 !== exp_m) begin
            errors++;
            $display("FAIL %s_mis: misaligned=%b expected %b", name, mis0, exp_m);
        end
`endif
    endtask

    // Same as step0 for the word-aligned instance (mask low 2 bits, flag on nonzero low bits).
    task automatic step1(input logic c, input logic l, input logic [W-1:0] d, input string name);
        logic [W-1:0] exp_pc;
        logic         exp_m;
        @(negedge clk);
        clr1 = c; load1 = l; pc_in1 = d;
        #1;
        checks++;
        if (pc_out1 !== m1) begin
            errors++;
            $display("FAIL %s_comb: pc_out=%h expected %h", name, pc_out1, m1);
        end
        if (c) begin
            m1 = RV1; mm1 = 1'b0;
        end else if (l) begin
            m1 = {d[W-1:2], 2'b00};
            mm1 = (d[1:0] != 2'b00);
        end
        q1.push_back(m1);
        qm1.push_back(mm1);
        @(posedge clk);
        #1;
        exp_pc = q1.pop_front();
        exp_m  = qm1.pop_front();
        checks++;
        if (pc_out1 !== exp_pc) begin
            errors++;
            $display("FAIL %s: pc_out=%h expected %h", name, pc_out1, exp_pc);
        end
`ifdef PC_REGISTER_MISALIGN_EN
        checks++;
        if (mis1 !== exp_m) begin
            errors++;
            $display("FAIL %s_mis: misaligned=%b expected %b", name, mis1, exp_m);
        end
`endif
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (pc_out0 !== 32'h0000_0000) begin
            errors++;
            $display("FAIL powerup0: pc_out=%h expected %h", pc_out0, 32'h0000_0000);
        end
        checks++;
        if (pc_out1 !== RV1) begin
            errors++;
            $display("FAIL powerup1: pc_out=%h expected %h", pc_out1, RV1);
        end
        step0(1'b0, 1'b0, 32'h0000_000F, "noload_a");
        step0(1'b0, 1'b0, 32'h0000_000F, "noload_b");
    endtask

    task automatic test_clear_priority();
        step0(1'b1, 1'b1, 32'h0000_0007, "clr_load_a");
        step0(1'b1, 1'b1, 32'h0000_0007, "clr_load_b");
    endtask

    task automatic test_load_hold();
        step0(1'b0, 1'b1, 32'h0000_0007, "load7");
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, 32'h0000_0003, "hold7");
    endtask

    task automatic test_back_to_back();
        step0(1'b0, 1'b1, 32'h0000_0004, "b2b_4");
        step0(1'b0, 1'b1, 32'h0000_0008, "b2b_8");
        step0(1'b0, 1'b1, 32'hFFFF_FFFC, "b2b_fffffffc");
        step0(1'b0, 1'b1, 32'hA5A5_5A5B, "b2b_full_width");
        step0(1'b0, 1'b1, $urandom(), "b2b_random");
        step0(1'b0, 1'b0, $urandom(), "b2b_hold");
    endtask

    task automatic test_align();
        step1(1'b1, 1'b0, 32'h0000_0000, "al_clr");
        step1(1'b0, 1'b1, 32'h0000_0013, "al_load13");
        step1(1'b0, 1'b0, 32'h0000_0002, "al_hold");
        step1(1'b0, 1'b1, 32'h0000_0014, "al_load14");
        step1(1'b0, 1'b1, 32'hFFFF_FFFF, "al_loadff");
        step1(1'b1, 1'b1, 32'h0000_0013, "al_clr_mis");
        step1(1'b0, 1'b1, 32'h8000_0002, "al_load_hi");
    endtask

    task automatic test_mid_clear();
        step0(1'b0, 1'b1, 32'h0000_0100, "mid_100");
        step0(1'b1, 1'b1, 32'h0000_0200, "mid_clr");
        step0(1'b0, 1'b1, 32'h0000_0200, "mid_200");
    endtask

    initial begin
        test_reset();
        test_clear_priority();
        test_load_hold();
        test_back_to_back();
        test_align();
        test_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
